// File: rtl/cv32e40p_obi_data_responder.sv
// OBI memory-side responder: grants requests, applies writes and captures reads at
// the grant edge, and returns in-order responses after a fixed latency.
module cv32e40p_obi_data_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int RESP_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_gnt_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic [31:0]              mem [MEM_WORDS];
    logic [CNT_W-1:0]         outstanding;
    logic [RESP_LATENCY:1]    vld_pipe;
    resp_t [RESP_LATENCY:1]   resp_pipe;
    resp_t                    resp_in;
    logic                     accept;
    logic                     addr_err;
    logic                     slot_free;
    logic [IDX_W-1:0]         idx;
    logic                     unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];

    assign idx      = addr_i[IDX_W+1:2];
    assign addr_err = |addr_i[31:IDX_W+2];

    // A retiring response frees its slot in the same cycle.
    assign slot_free = (outstanding < CNT_W'(MAX_OUTSTANDING)) | rvalid_o;
    assign gnt_o     = req_i & ~stall_gnt_i & ~rst_i & slot_free;
    assign accept    = req_i & gnt_o;

    always_comb begin
        resp_in       = '0;
        resp_in.err   = addr_err;
        if (!we_i && !addr_err)
            resp_in.rdata = mem[idx];
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && !addr_err) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b])
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    // Idle stages carry zeros so rdata_o/err_o stay 0 between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe  <= '0;
            resp_pipe <= '0;
        end else begin
            vld_pipe[1]  <= accept;
            resp_pipe[1] <= accept ? resp_in : '0;
            for (int i = 2; i <= RESP_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                resp_pipe[i] <= resp_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            outstanding <= '0;
        else if (accept && !rvalid_o)
            outstanding <= outstanding + CNT_W'(1);
        else if (!accept && rvalid_o)
            outstanding <= outstanding - CNT_W'(1);
    end

    assign rvalid_o = vld_pipe[RESP_LATENCY];
    assign rdata_o  = resp_pipe[RESP_LATENCY].rdata;
    assign err_o    = resp_pipe[RESP_LATENCY].err;

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Bench for the OBI responder: two instances (latency 1 and 3) share one stimulus
// stream and are each checked every cycle against a queue-based transaction model.
module tb_cv32e40p_obi_data_responder;

    localparam int MW = 32;

    logic        clk = 1'b0;
    logic        rst, stall, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata [2];

    always #5 clk = ~clk;

    cv32e40p_obi_data_responder #(.MEM_WORDS(MW), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .stall_gnt_i(stall), .req_i(req), .gnt_o(gnt[0]),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    cv32e40p_obi_data_responder #(.MEM_WORDS(MW), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_l3 (
        .clk_i(clk), .rst_i(rst), .stall_gnt_i(stall), .req_i(req), .gnt_o(gnt[1]),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] mm [2][MW];
    int          lat  [2] = '{1, 3};
    int          maxo [2] = '{2, 2};
    int          cyc, checks, errors;
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          gnt_cnt [2];
    logic [1:0]  gnt_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req = r; we = w; addr = a; wdata = d; be = b;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        @(negedge clk);
        gnt_seen = gnt;
        for (int d = 0; d < 2; d++) begin
            logic due, eg;
            exp_t e;
            int   idx;
            due = (q[d].size() > 0) && (q[d][0].due == cyc);
            if (gnt[d] && req) gnt_cnt[d]++;
            if (rst) begin
                chk($sformatf("gnt_in_reset%0d", d), gnt[d], 0);
                q[d].delete();
            end else begin
                eg = req && !stall && ((q[d].size() < maxo[d]) || due);
                chk($sformatf("gnt%0d@%0d", d, cyc), gnt[d], eg);
                chk($sformatf("rvalid%0d@%0d", d, cyc), rvalid[d], due);
                if (due) begin
                    chk($sformatf("rdata%0d@%0d", d, cyc), rdata[d], q[d][0].rdata);
                    chk($sformatf("err%0d@%0d", d, cyc), err[d], q[d][0].err);
                    last_rdata[d] = rdata[d];
                    last_err[d]   = err[d];
                    void'(q[d].pop_front());
                end
                if (eg) begin
                    idx     = int'(addr >> 2);
                    e.err   = (idx >= MW);
                    e.rdata = (we || e.err) ? 32'h0 : mm[d][idx];
                    e.due   = cyc + lat[d];
                    q[d].push_back(e);
                    if (we && !e.err)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mm[d][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  pat;
        int          gc;
        cyc = 0; checks = 0; errors = 0;
        gnt_cnt = '{0, 0};
        rst = 1'b1; stall = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_rvalid%0d", d), rvalid[d], 0);
            chk($sformatf("reset_rdata%0d", d), rdata[d], 0);
            chk($sformatf("reset_err%0d", d), err[d], 0);
        end
        rst = 1'b0;

        // Preload every word; two cycles each so both instances take it.
        for (int k = 0; k < MW; k++) begin
            w = $urandom;
            drive(1'b1, 1'b1, k * 4, w, 4'hF);
            step(); step();
        end
        idle(5);

        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); step();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);        step();
        idle(1);
        chk("t1_rdata", last_rdata[0], 32'hDEADBEEF);
        chk("t1_err", last_err[0], 0);
        idle(5);

        drive(1'b1, 1'b1, 32'h10, 32'h0000AB00, 4'b0010); step();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);           step();
        idle(1);
        chk("t2_rdata", last_rdata[0], 32'hDEADABEF);
        idle(5);

        pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, i * 4, 32'h0, 4'h0);
            step();
            pat = {pat[4:0], gnt_seen[1]};
        end
        chk("t3_gnt_pattern", pat, 6'b110110);
        idle(6);

        drive(1'b1, 1'b0, 4 * MW, 32'h0, 4'h0); step();
        idle(1);
        chk("t4_read_err", last_err[0], 1);
        chk("t4_read_rdata", last_rdata[0], 0);
        drive(1'b1, 1'b1, 4 * MW, 32'h12345678, 4'hF); step();
        idle(1);
        chk("t4_write_err", last_err[0], 1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0); step();
        idle(1);
        chk("t4_word0_intact", last_rdata[0], mm[0][0]);
        idle(5);

        gc = gnt_cnt[0];
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i % 2) * 4, 32'h0, 4'h0);
            step();
        end
        stall = 1'b0;
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0); step();
        idle(1);
        chk("t5_grants", gnt_cnt[0] - gc, 1);
        chk("t5_rdata", last_rdata[0], mm[0][1]);
        idle(5);

        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0); step();
        drive(1'b1, 1'b0, 32'hC, 32'h0, 4'h0); step();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h14, 32'h0, 4'h0); step();
        chk("t6_first_gnt", gnt_seen, 2'b11);
        idle(6);

        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                addr = 32'hF000_0000 | $urandom_range(0, 255);
            else
                addr = $urandom_range(0, MW + 3) * 4 + $urandom_range(0, 3);
            req   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            be    = 4'($urandom_range(0, 15));
            wdata = $urandom;
            step();
        end
        rst = 1'b0; stall = 1'b0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
